// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response types and constant address-phase attributes
package obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } obi_rsp_t;

  localparam int RSP_W = $bits(obi_rsp_t);

  localparam logic [1:0] OBI_MEMTYPE_DEFAULT = 2'b00;
  localparam logic [2:0] OBI_PROT_DEFAULT    = 3'b111;
  localparam logic [5:0] OBI_ATOP_NONE       = 6'b000000;

endpackage

// File: rtl/obi_rsp_fifo.sv
// rtl/obi_rsp_fifo.sv - response FIFO with a registered head word
module obi_rsp_fifo
  import obi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [RSP_W-1:0] din_i,
  input  logic             pop_i,
  output logic [RSP_W-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [RSP_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RSP_W-1:0] dout_q, dout_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign dout_o  = dout_q;

  // The head is precomputed so the output is a flop; a push into an
  // emptying FIFO becomes the head directly.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
    rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (cnt_d == '0)                            dout_d = '0;
    else if (push_i && (cnt_q == CW'(pop_i)))   dout_d = din_i;
    else                                        dout_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/obi_data_initiator.sv
// rtl/obi_data_initiator.sv - command-driven OBI data-bus initiator
module obi_data_initiator
  import obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_we_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic [1:0]  data_memtype_o,
  output logic [2:0]  data_prot_o,
  output logic        data_dbg_o,
  output logic [5:0]  data_atop_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        data_exokay_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0]              occ_q, occ_d, inflight_q, inflight_d, we_slot;
  logic                       req_q, req_d, proto_err_q, proto_err_d;
  obi_req_t                   areq_q, areq_d;
  logic [MAX_OUTSTANDING-1:0] weq_q, weq_d;
  logic                       cmd_accept, grant, beat_ok, rsp_pop;
  logic                       fifo_empty, fifo_full;
  obi_rsp_t                   fifo_din, fifo_dout;
  logic                       unused_sig;

  // A pop in the same cycle does not free a slot for the command port.
  assign cmd_ready_o = (occ_q < CW'(MAX_OUTSTANDING)) && (!req_q || data_gnt_i);
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign grant       = req_q && data_gnt_i;
  assign beat_ok     = data_rvalid_i && (inflight_q != '0);
  assign rsp_valid_o = !fifo_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (cmd_accept && !rsp_pop)      occ_d = occ_q + CW'(1);
    else if (!cmd_accept && rsp_pop) occ_d = occ_q - CW'(1);

    req_d  = req_q;
    areq_d = areq_q;
    if (cmd_accept) begin
      req_d        = 1'b1;
      areq_d.addr  = cmd_addr_i;
      areq_d.we    = cmd_we_i;
      areq_d.be    = cmd_be_i;
      areq_d.wdata = cmd_wdata_i;
    end else if (grant) begin
      req_d = 1'b0;
    end

    inflight_d = inflight_q;
    if (grant && !beat_ok)      inflight_d = inflight_q + CW'(1);
    else if (!grant && beat_ok) inflight_d = inflight_q - CW'(1);

    // Type tags leave from bit 0 as responses return; a grant appends behind them.
    weq_d   = beat_ok ? (weq_q >> 1) : weq_q;
    we_slot = beat_ok ? (inflight_q - CW'(1)) : inflight_q;
    if (grant) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (we_slot == CW'(i)) weq_d[i] = areq_q.we;
      end
    end

    proto_err_d = proto_err_q || (data_rvalid_i && (inflight_q == '0));

    fifo_din.rdata = weq_q[0] ? 32'h0 : data_rdata_i;
    fifo_din.err   = data_err_i;
    fifo_din.we    = weq_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q       <= '0;
      inflight_q  <= '0;
      req_q       <= 1'b0;
      areq_q      <= '0;
      weq_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      req_q       <= req_d;
      areq_q      <= areq_d;
      weq_q       <= weq_d;
      proto_err_q <= proto_err_d;
    end
  end

  obi_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (beat_ok),
    .din_i   (fifo_din),
    .pop_i   (rsp_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rsp_rdata_o    = fifo_dout.rdata;
  assign rsp_err_o      = fifo_dout.err;
  assign rsp_we_o       = fifo_dout.we;
  assign data_req_o     = req_q;
  assign data_addr_o    = areq_q.addr;
  assign data_we_o      = areq_q.we;
  assign data_be_o      = areq_q.be;
  assign data_wdata_o   = areq_q.wdata;
  assign data_memtype_o = OBI_MEMTYPE_DEFAULT;
  assign data_prot_o    = OBI_PROT_DEFAULT;
  assign data_dbg_o     = 1'b0;
  assign data_atop_o    = OBI_ATOP_NONE;
  assign busy_o         = (occ_q != '0);
  assign proto_err_o    = proto_err_q;
  assign unused_sig     = ^{data_exokay_i, fifo_full};

endmodule

// File: tb/tb_obi_data_initiator.sv
// tb/tb_obi_data_initiator.sv - scoreboard bench with random memory timing
module tb_obi_data_initiator;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } slv_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_we_o;
  logic        data_req_o, data_gnt_i = 1'b0;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [1:0]  data_memtype_o;
  logic [2:0]  data_prot_o;
  logic        data_dbg_o;
  logic [5:0]  data_atop_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        data_err_i = 1'b0, data_exokay_i = 1'b0;
  logic        busy_o, proto_err_o;

  obi_data_initiator #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_memtype_o(data_memtype_o), .data_prot_o(data_prot_o), .data_dbg_o(data_dbg_o), .data_atop_o(data_atop_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .data_exokay_i(data_exokay_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, acc_cnt = 0;
  int unsigned vld_prob = 100, gnt_prob = 100, rv_prob = 100, rdy_prob = 100;
  bit          spur_pend = 1'b0;
  cmd_t        cmd_q[$];
  exp_t        exp_q[$];
  slv_t        slv_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return a >= 32'hFFFF_FFF0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = nw[b*8 +: 8];
    return old;
  endfunction

  // Reference model: memory updated in command order, expected response queued at accept
  task automatic model_issue(input cmd_t c);
    exp_t        e;
    logic [31:0] cur;
    cur     = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0;
    e.we    = c.we;
    e.err   = is_err(c.addr);
    e.rdata = (c.we || e.err) ? 32'h0 : cur;
    if (c.we && !e.err) ref_mem[c.addr] = merge(cur, c.wdata, c.be);
    exp_q.push_back(e);
  endtask

  task automatic slave_access();
    slv_t        s;
    logic [31:0] a, cur;
    a       = data_addr_o;
    cur     = slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    s.err   = is_err(a);
    s.rdata = data_we_o ? $urandom : (s.err ? 32'h0 : cur);
    if (data_we_o && !s.err) slv_mem[a] = merge(cur, data_wdata_o, data_be_o);
    slv_q.push_back(s);
  endtask

  initial begin : driver
    bit spur_now;
    forever begin
      @(negedge clk);
      spur_now  = spur_pend;
      spur_pend = 1'b0;
      if (cmd_q.size() > 0 && int'($urandom_range(99)) < int'(vld_prob)) begin
        cmd_valid_i = 1'b1;
        cmd_addr_i  = cmd_q[0].addr;
        cmd_we_i    = cmd_q[0].we;
        cmd_be_i    = cmd_q[0].be;
        cmd_wdata_i = cmd_q[0].wdata;
      end else begin
        cmd_valid_i = 1'b0;
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
      end
      data_gnt_i = int'($urandom_range(99)) < int'(gnt_prob);
      if (spur_now) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = $urandom;
        data_err_i    = 1'b0;
      end else if (slv_q.size() > 0 && int'($urandom_range(99)) < int'(rv_prob)) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = slv_q[0].rdata;
        data_err_i    = slv_q[0].err;
      end else begin
        data_rvalid_i = 1'b0;
        data_rdata_i  = $urandom;
        data_err_i    = 1'($urandom_range(1));
      end
      data_exokay_i = 1'($urandom_range(1));
      rsp_ready_i   = int'($urandom_range(99)) < int'(rdy_prob);
      #1;
      if (cmd_valid_i && cmd_ready_o) begin
        model_issue(cmd_q.pop_front());
        acc_cnt++;
      end
      if (data_rvalid_i && !spur_now) void'(slv_q.pop_front());
      if (data_req_o && data_gnt_i) slave_access();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "rsp_unexpected", {rsp_rdata_o, rsp_err_o, rsp_we_o}, 0);
        end else begin
          e = exp_q.pop_front();
          check({rsp_rdata_o, rsp_err_o, rsp_we_o} === {e.rdata, e.err, e.we}, "rsp_data",
                {rsp_rdata_o, rsp_err_o, rsp_we_o}, {e.rdata, e.err, e.we});
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    cmd_t c;
    c.addr = a; c.we = we; c.be = be; c.wdata = wd;
    cmd_q.push_back(c);
  endtask

  task automatic wait_acc(input string name);
    int  base;
    bit  done;
    base = acc_cnt;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc();
      done = (acc_cnt != base);
    end
    check(done, name, 64'(acc_cnt - base), 1);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      cyc();
      done = (cmd_q.size() == 0) && (exp_q.size() == 0) && (slv_q.size() == 0) && !busy_o;
    end
    check(done, name, 64'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(data_req_o === 1'b0, {tag, "_req"}, 64'(data_req_o), 0);
    check(cmd_ready_o === 1'b1, {tag, "_cmd_ready"}, 64'(cmd_ready_o), 1);
    check({data_addr_o, data_wdata_o, data_we_o, data_be_o} === '0, {tag, "_aphase"},
          {data_addr_o, data_wdata_o}, 0);
    check({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o} === '0, {tag, "_rsp"},
          {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o}, 0);
    check({busy_o, proto_err_o} === 2'b00, {tag, "_busy_perr"}, {busy_o, proto_err_o}, 0);
    check({data_memtype_o, data_prot_o, data_dbg_o, data_atop_o} === {2'b00, 3'b111, 1'b0, 6'b0},
          {tag, "_attr"}, {data_memtype_o, data_prot_o, data_dbg_o, data_atop_o}, {2'b00, 3'b111, 7'b0});
  endtask

  initial begin : main
    cmd_t        c;
    int          base;
    bit          seen;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    cyc();

    // Single write, zero-wait memory: req at N+1, response at N+3
    push_cmd(32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    wait_acc("t1_accept");
    cyc();
    check(data_req_o === 1'b1, "t1_req_n1", 64'(data_req_o), 1);
    cyc();
    check(rsp_valid_o === 1'b0, "t1_rsp_n2", 64'(rsp_valid_o), 0);
    check(data_req_o === 1'b0, "t1_req_drop", 64'(data_req_o), 0);
    cyc();
    check(rsp_valid_o === 1'b1, "t1_rsp_n3", 64'(rsp_valid_o), 1);
    push_cmd(32'h0000_1000, 1'b0, 4'hF, 32'h0);
    wait_drain(50, "t1_drain");

    // Grant stall: address phase must hold for 5 cycles
    gnt_prob = 0;
    c.addr = 32'h0000_2000; c.we = 1'b1; c.be = 4'h5; c.wdata = 32'hCAFE_F00D;
    cmd_q.push_back(c);
    wait_acc("stall_accept");
    for (int i = 0; i < 5; i++) begin
      cyc();
      check({data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o} ===
            {1'b1, c.addr, c.we, c.be, c.wdata}, "stall_hold",
            {data_addr_o, data_wdata_o}, {c.addr, c.wdata});
    end
    gnt_prob = 100;
    wait_drain(50, "stall_drain");

    // Back-to-back reads with response port blocked
    for (int i = 0; i < 4; i++) push_cmd(32'(4 * i), 1'b1, 4'hF, $urandom);
    wait_drain(100, "b2b_prefill");
    rdy_prob = 0;
    base = acc_cnt;
    for (int i = 0; i < 4; i++) push_cmd(32'(4 * i), 1'b0, 4'hF, 32'h0);
    repeat (12) cyc();
    check(acc_cnt - base == 2, "b2b_accepts", 64'(acc_cnt - base), 2);
    check(cmd_ready_o === 1'b0, "b2b_full_ready", 64'(cmd_ready_o), 0);
    check(busy_o === 1'b1, "b2b_busy", 64'(busy_o), 1);
    rdy_prob = 100;
    wait_drain(100, "b2b_drain");

    // Error on one read, clean response afterwards
    push_cmd(32'hFFFF_FFF0, 1'b0, 4'hF, 32'h0);
    push_cmd(32'h0000_1000, 1'b0, 4'hF, 32'h0);
    wait_drain(50, "err_drain");

    // Randomized traffic and memory timing
    for (int i = 0; i < 160; i++) begin
      if (i % 20 == 0) begin
        vld_prob = $urandom_range(100, 30);
        gnt_prob = $urandom_range(100, 25);
        rv_prob  = $urandom_range(100, 25);
        rdy_prob = $urandom_range(100, 20);
      end
      c.addr  = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3))
                                         : 32'h0000_0100 + 32'(4 * $urandom_range(7));
      c.we    = 1'($urandom_range(1));
      c.be    = 4'($urandom_range(15));
      c.wdata = $urandom;
      cmd_q.push_back(c);
    end
    wait_drain(8000, "rand_drain");
    vld_prob = 100; gnt_prob = 100; rv_prob = 100; rdy_prob = 100;

    // Spurious response beat with nothing granted
    spur_pend = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check(proto_err_o === 1'b1, "spur_perr", 64'(proto_err_o), 1);
      check(rsp_valid_o === 1'b0, "spur_no_rsp", 64'(rsp_valid_o), 0);
    end

    // Reset with a request pending and a response queued
    rdy_prob = 0;
    push_cmd(32'h0000_1000, 1'b0, 4'hF, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = rsp_valid_o;
    end
    check(seen, "rst_pre_rsp", 64'(rsp_valid_o), 1);
    gnt_prob = 0;
    push_cmd(32'h0000_1004, 1'b0, 4'hF, 32'h0);
    wait_acc("rst_pre_accept");
    cyc();
    check(data_req_o === 1'b1, "rst_pre_req", 64'(data_req_o), 1);
    rst_i = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    exp_q.delete();
    slv_q.delete();
    cmd_q.delete();
    gnt_prob = 100;
    rdy_prob = 100;
    push_cmd(32'h0000_3000, 1'b1, 4'h3, 32'h1234_5678);
    push_cmd(32'h0000_3000, 1'b0, 4'hF, 32'h0);
    wait_drain(50, "post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
